// File: rtl/operand_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : operand_dispatcher
// Description : Upstream feeder for the multicycle add/sub datapath.
//               Assembles four-operand jobs (A, B, C, D + mode) from a byte
//               stream into a two-entry job queue. It issues one job at a time
//               to the datapath and holds the operands stable until done.
//               It then returns the captured result on a valid/ready port.
//               A watchdog aborts a job whose done never arrives.
// Ports       : clock, reset (async, active-low)
//               in_valid/in_ready/in_data/in_mode   - operand byte stream
//               au_start/au_mode/au_a..au_d         - datapath request
//               au_done/au_result                   - datapath response
//               res_valid/res_ready/res_data/
//               res_mode/res_timeout                - result stream
//               busy                                - queue or FSM active
// Revision    : 1.0 - initial release
// ============================================================================
module operand_dispatcher #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             au_start,
    output logic             au_mode,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [WIDTH-1:0] au_c,
    output logic [WIDTH-1:0] au_d,
    input  logic             au_done,
    input  logic [WIDTH-1:0] au_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_mode,
    output logic             res_timeout,
    output logic             busy
);

    localparam int               c_WDW       = $clog2(TIMEOUT);
    localparam logic [c_WDW-1:0] c_WDOG_LAST = c_WDW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    // Job queue storage (two slots, ring-addressed)
    logic [WIDTH-1:0] r_q_a    [0:1];
    logic [WIDTH-1:0] r_q_b    [0:1];
    logic [WIDTH-1:0] r_q_c    [0:1];
    logic [WIDTH-1:0] r_q_d    [0:1];
    logic             r_q_mode [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [1:0]       r_byte_cnt;

    // Dispatch FSM and datapath-facing registers
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_WDW-1:0] r_wdog;
    logic             r_au_mode;
    logic [WIDTH-1:0] r_au_a;
    logic [WIDTH-1:0] r_au_b;
    logic [WIDTH-1:0] r_au_c;
    logic [WIDTH-1:0] r_au_d;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_mode;
    logic             r_res_timeout;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_commit;
    logic             w_pop;
    logic             w_issue;
    logic             w_done_cap;
    logic             w_expire;

    // A partially assembled job lives in the write slot without being
    // counted, so only committed jobs throttle the input.
    assign w_in_ready = (r_count < 2'd2);
    assign w_accept   = in_valid && w_in_ready;
    assign w_commit   = w_accept && (r_byte_cnt == 2'd3);
    assign w_pop      = (r_state == c_RESP) && res_ready;

    // ------------------------------------------------------------------------
    // Byte assembly and queue bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_q_a[i]    <= '0;
                r_q_b[i]    <= '0;
                r_q_c[i]    <= '0;
                r_q_d[i]    <= '0;
                r_q_mode[i] <= 1'b0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_byte_cnt <= 2'd0;
        end else begin
            if (w_accept) begin
                case (r_byte_cnt)
                    2'd0: begin
                        r_q_a[r_wr_ptr]    <= in_data;
                        r_q_mode[r_wr_ptr] <= in_mode;
                    end
                    2'd1:    r_q_b[r_wr_ptr] <= in_data;
                    2'd2:    r_q_c[r_wr_ptr] <= in_data;
                    default: r_q_d[r_wr_ptr] <= in_data;
                endcase
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_commit) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Commit and pop in the same cycle leave the count unchanged
            if (w_commit && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_commit) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Dispatch FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_cap  = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Datapath must have released done before the next start
                if ((r_count != 2'd0) && !au_done) begin
                    w_issue     = 1'b1;
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                // done takes priority over a coincident watchdog expiry
                if (au_done) begin
                    w_done_cap  = 1'b1;
                    w_state_nxt = c_RESP;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (res_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Dispatch FSM: state, operand latch, watchdog and result capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_wdog        <= '0;
            r_au_mode     <= 1'b0;
            r_au_a        <= '0;
            r_au_b        <= '0;
            r_au_c        <= '0;
            r_au_d        <= '0;
            r_res_data    <= '0;
            r_res_mode    <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_au_a    <= r_q_a[r_rd_ptr];
                r_au_b    <= r_q_b[r_rd_ptr];
                r_au_c    <= r_q_c[r_rd_ptr];
                r_au_d    <= r_q_d[r_rd_ptr];
                r_au_mode <= r_q_mode[r_rd_ptr];
                r_wdog    <= '0;
            end else if (r_state == c_ISSUE) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_done_cap) begin
                r_res_data    <= au_result;
                r_res_mode    <= r_au_mode;
                r_res_timeout <= 1'b0;
            end else if (w_expire) begin
                r_res_data    <= '0;
                r_res_mode    <= r_au_mode;
                r_res_timeout <= 1'b1;
            end
        end
    end

    // Outputs decoded straight from state so an async reset drops au_start
    assign in_ready    = w_in_ready;
    assign au_start    = (r_state == c_ISSUE);
    assign au_mode     = r_au_mode;
    assign au_a        = r_au_a;
    assign au_b        = r_au_b;
    assign au_c        = r_au_c;
    assign au_d        = r_au_d;
    assign res_valid   = (r_state == c_RESP);
    assign res_data    = r_res_data;
    assign res_mode    = r_res_mode;
    assign res_timeout = r_res_timeout;
    assign busy        = (r_count != 2'd0) || (r_state != c_IDLE);

endmodule
`default_nettype wire
